// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_pkg
// Description : Shared widths and encodings for the instruction/load-store
//               memory arbiter: FSM state codes and read-response tags.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arbiter_pkg;

    // Default data/instruction widths of the CPU datapath.
    localparam int DSIZE = 16;
    localparam int ISIZE = 16;

    // Arbiter FSM state encoding.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Owner of the read data returning from memory in the next cycle.
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_IF   = 2'd1;
    localparam logic [1:0] TAG_LS   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_prio
// Description : Two-way grant logic for the IF and LS ports. LS normally
//               wins a conflict; IF wins once it has been refused MAX_WAIT
//               times in a row, which bounds fetch starvation.
// Ports       : clk, rst         - clock, async active-high reset
//               run              - grants allowed (arbiter out of INIT)
//               if_req, ls_req   - requests from the two ports
//               if_gnt, ls_gnt   - combinational grants
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_prio
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);

    localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_if_starved;

    assign w_if_starved = (r_wait_cnt == c_WAIT_MAX);

    assign if_gnt = run & if_req & (~ls_req | w_if_starved);
    assign ls_gnt = run & ls_req & ~if_gnt;

    // Counts consecutive cycles in which IF asked and was refused. This also
    // runs during INIT, since IF is refused there as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_if_starved) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one single-port memory (registered address, 1-cycle
//               read latency) between the instruction-fetch (IF) and
//               load/store (LS) ports. Holds off all grants for INIT_CYC
//               cycles after reset, grants one requester per cycle and tags
//               each read so its data is flagged valid on the right port one
//               cycle later.
// Ports       : clk, rst                         - clock, async reset
//               if_req/if_addr/if_gnt/if_rvalid  - fetch port
//               ls_req/ls_wen/ls_addr/ls_wdata/
//               ls_gnt/ls_rvalid                 - load/store port
//               rdata                            - shared read data
//               mem_addr/mem_wen/mem_wdata/
//               mem_rdata                        - memory side
//               busy                             - high while in INIT
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DSIZE,
    parameter int WDATA_W  = DSIZE,
    parameter int RDATA_W  = ISIZE,
    parameter int INIT_CYC = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    input  logic               ls_req,
    input  logic               ls_wen,
    input  logic [ADDR_W-1:0]  ls_addr,
    input  logic [WDATA_W-1:0] ls_wdata,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [RDATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDATA_W-1:0] mem_rdata,
    output logic               busy
);

    localparam int                  c_INIT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYC - 1);
    localparam logic [c_INIT_W-1:0] c_INIT_ONE  = c_INIT_W'(1);

    logic [0:0]        r_state;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic              r_busy;
    logic [1:0]        r_tag;
    logic [ADDR_W-1:0] r_last_addr;
    logic              w_run;

    assign w_run = (r_state == ST_RUN);

    imem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .run    (w_run),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt)
    );

    // INIT lasts exactly INIT_CYC clock edges with rst low; RUN is terminal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_INIT_ONE;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // The memory registers its address on the same edge as this tag, so the
    // tag lines up with the data appearing on mem_rdata in the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= TAG_NONE;
        end else if (if_gnt) begin
            r_tag <= TAG_IF;
        end else if (ls_gnt && !ls_wen) begin
            r_tag <= TAG_LS;
        end else begin
            r_tag <= TAG_NONE;
        end
    end

    // Address of the most recent grant, replayed on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_addr <= '0;
        end else if (if_gnt) begin
            r_last_addr <= if_addr;
        end else if (ls_gnt) begin
            r_last_addr <= ls_addr;
        end
    end

    always_comb begin
        mem_addr = r_last_addr;
        if (!w_run) begin
            mem_addr = '0;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_addr = ls_addr;
        end
    end

    assign mem_wen   = ls_gnt & ls_wen;
    assign mem_wdata = ls_gnt ? ls_wdata : '0;

    assign if_rvalid = (r_tag == TAG_IF);
    assign ls_rvalid = (r_tag == TAG_LS);
    assign rdata     = mem_rdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire
